// File: rtl/pixel_stream_framer_if.sv
// Pixel stream handshake bundle.
//   valid/data/ready : beat transfer, a beat moves when valid & ready
//   last             : end-of-line marker
//   user             : start-of-frame marker
//   keep             : byte enables
// The raw input stream carries only valid/data/ready, so the slave modport
// exposes just those; the framed output stream uses the full master modport.
interface pixel_stream_framer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH-1:0]   data;
   logic                    last;
   logic                    user;
   logic [DATA_WIDTH/8-1:0] keep;

   modport master (
      output valid, data, last, user, keep,
      input  ready
   );

   modport slave (
      input  valid, data,
      output ready
   );
endinterface

// File: rtl/pixel_stream_framer.sv
// Pixel stream framer: counts words per line and lines per frame on a raw
// pixel stream and tags each beat with last (end-of-line) and user
// (start-of-frame). Beats pass through a 2-entry skid buffer so that both
// the output stream and the input ready are registered. Frame geometry is
// sampled only at frame boundaries.
// Ports:
//   axi_clk        clock, rising edge
//   axi_reset      asynchronous active-high reset
//   s_axis         raw input stream (valid/data in, ready out)
//   m_axis         framed output stream (valid/data/last/user/keep out, ready in)
//   cfg_enable     run frames while high
//   cfg_line_words words per line
//   cfg_lines      lines per frame
//   frame_done     one-cycle pulse after the last beat of a frame is accepted
//   frame_count    completed-frame counter, wraps
module pixel_stream_framer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 12
) (
   input  logic                 axi_clk,
   input  logic                 axi_reset,
   pixel_stream_framer_if.slave  s_axis,
   pixel_stream_framer_if.master m_axis,
   input  logic                 cfg_enable,
   input  logic [CNT_WIDTH-1:0] cfg_line_words,
   input  logic [CNT_WIDTH-1:0] cfg_lines,
   output logic                 frame_done,
   output logic [CNT_WIDTH-1:0] frame_count
);

   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [CNT_WIDTH-1:0]  word_cnt;
   logic [CNT_WIDTH-1:0]  line_cnt;
   logic [CNT_WIDTH-1:0]  words_lat;
   logic [CNT_WIDTH-1:0]  lines_lat;
   logic                  s_ready;

   // Skid entries: _p0 is the head driving the output, _p1 the overflow slot.
   logic [DATA_WIDTH-1:0] data_p0;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  last_p0;
   logic                  last_p1;
   logic                  user_p0;
   logic                  user_p1;
   logic [1:0]            occ;
   logic [1:0]            occ_nxt;
   logic                  vld_p0;

   logic                  accept;
   logic                  pop;
   logic                  beat_user;
   logic                  beat_last;
   logic                  line_end;
   logic                  frame_end;
   logic                  cfg_ok;

   always_comb begin
      // s_ready is only ever registered high for a RUN cycle, so accept
      // implies the FSM is running.
      accept    = s_axis.valid & s_ready;
      pop       = vld_p0 & m_axis.ready;
      beat_user = (word_cnt == '0) && (line_cnt == '0);
      beat_last = (word_cnt == words_lat - CNT_ONE);
      line_end  = (line_cnt == lines_lat - CNT_ONE);
      frame_end = accept & beat_last & line_end;
      cfg_ok    = cfg_enable && (cfg_line_words != '0) && (cfg_lines != '0);

      occ_nxt = occ;
      if (accept && !pop) begin
         occ_nxt = occ + 2'd1;
      end else if (pop && !accept) begin
         occ_nxt = occ - 2'd1;
      end

      state_nxt = state;
      case (state)
         IDLE:    if (cfg_ok) state_nxt = RUN;
         RUN:     if (frame_end && !cfg_ok) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         state       <= IDLE;
         word_cnt    <= '0;
         line_cnt    <= '0;
         words_lat   <= '0;
         lines_lat   <= '0;
         s_ready     <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         data_p0     <= '0;
         data_p1     <= '0;
         last_p0     <= 1'b0;
         last_p1     <= 1'b0;
         user_p0     <= 1'b0;
         user_p1     <= 1'b0;
         occ         <= 2'd0;
         vld_p0      <= 1'b0;
      end else begin
         state      <= state_nxt;
         // Ready looks at next-cycle occupancy so a full buffer is never offered a beat.
         s_ready    <= (state_nxt == RUN) && (occ_nxt != 2'd2);
         frame_done <= frame_end;
         if (frame_end) begin
            frame_count <= frame_count + CNT_ONE;
         end

         // Framing counters
         if (state == IDLE) begin
            if (cfg_ok) begin
               words_lat <= cfg_line_words;
               lines_lat <= cfg_lines;
               word_cnt  <= '0;
               line_cnt  <= '0;
            end
         end else if (accept) begin
            if (beat_last) begin
               word_cnt <= '0;
               if (line_end) begin
                  line_cnt <= '0;
                  // Geometry is only re-sampled here, so mid-frame edits wait.
                  if (cfg_ok) begin
                     words_lat <= cfg_line_words;
                     lines_lat <= cfg_lines;
                  end
               end else begin
                  line_cnt <= line_cnt + CNT_ONE;
               end
            end else begin
               word_cnt <= word_cnt + CNT_ONE;
            end
         end

         // Skid buffer, stage p0/p1
         occ    <= occ_nxt;
         vld_p0 <= (occ_nxt != 2'd0);
         if (accept && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
            data_p0 <= s_axis.data;
            last_p0 <= beat_last;
            user_p0 <= beat_user;
         end else if (pop && (occ == 2'd2)) begin
            data_p0 <= data_p1;
            last_p0 <= last_p1;
            user_p0 <= user_p1;
         end
         if (accept && (occ == 2'd1) && !pop) begin
            data_p1 <= s_axis.data;
            last_p1 <= beat_last;
            user_p1 <= beat_user;
         end
      end
   end

   assign s_axis.ready = s_ready;
   assign m_axis.valid = vld_p0;
   assign m_axis.data  = data_p0;
   assign m_axis.last  = last_p0;
   assign m_axis.user  = user_p0;
   assign m_axis.keep  = {KEEP_W{vld_p0}};

endmodule
